// File: rtl/spi_pin_arb.sv
// Shared SPI/GPIO pin group arbiter with glitch-free, guard-timed reconfiguration.
// Optional macro SPI_PIN_ARB_TIMEOUT_EN adds s_err_o and a WAIT timeout.
module spi_pin_arb #(
    parameter int   CS_W    = 1,
    parameter int   IO_W    = 0,
    parameter int   NCH     = 2,
    parameter int   GUARD   = 4,
    parameter logic CS_IDLE = 1'b1,
    parameter int   TMO     = 1024,
    localparam int  P       = CS_W + IO_W + 4,
    localparam int  CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    s_clk_i,
    input  logic                    s_rst_i,
    input  logic [P-1:0]            s_io_i,
    input  logic [NCH-1:0]          s_spi_clk_i,
    input  logic [NCH-1:0]          s_spi_dat_i,
    input  logic [NCH*(CS_W+1)-1:0] s_spi_cs_i,
    input  logic [NCH*(IO_W+1)-1:0] s_spi_io_i,
    input  logic                    s_cfg_vld_i,
    output logic                    s_cfg_rdy_o,
    input  logic [P-1:0]            s_cfg_sel_i,
    input  logic [CHW-1:0]          s_cfg_ch_i,
    output logic                    s_spi_clk_o,
    output logic                    s_spi_dat_o,
    output logic [CS_W:0]           s_spi_cs_o,
    output logic [IO_W:0]           s_spi_io_o,
    output logic [P-1:0]            s_cur_sel_o,
    output logic [CHW-1:0]          s_cur_ch_o,
    output logic                    s_busy_o
`ifdef SPI_PIN_ARB_TIMEOUT_EN
    ,
    output logic                    s_err_o
`endif
);

    localparam int CNTW = $clog2(GUARD + 1);
    localparam logic [CS_W:0] CS_OFF = {(CS_W+1){CS_IDLE}};
    localparam logic [P-1:0] PIN_RST = {{(IO_W+1){1'b0}}, CS_OFF, 2'b00};

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          state, state_d;
    logic [P-1:0]    cur_sel, cur_sel_d, pend_sel, pend_sel_d;
    logic [CHW-1:0]  cur_ch, cur_ch_d, pend_ch, pend_ch_d, req_ch;
    logic [CNTW-1:0] cnt, cnt_d;
    logic [P-1:0]    spi_vec, pin_q;
    logic [CS_W:0]   act_cs, pend_cs;
    logic            quiet, accept, same;

`ifdef SPI_PIN_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1);
    logic [TW-1:0] tmo, tmo_d;
    logic          err_d;
`endif

    always_comb begin
        spi_vec = '0;
        act_cs  = '0;
        pend_cs = '0;
        for (int c = 0; c < NCH; c++) begin
            if (cur_ch == CHW'(c)) begin
                spi_vec = {s_spi_io_i[c*(IO_W+1) +: IO_W+1],
                           s_spi_cs_i[c*(CS_W+1) +: CS_W+1],
                           s_spi_dat_i[c], s_spi_clk_i[c]};
                act_cs  = s_spi_cs_i[c*(CS_W+1) +: CS_W+1];
            end
            if (pend_ch == CHW'(c))
                pend_cs = s_spi_cs_i[c*(CS_W+1) +: CS_W+1];
        end
    end

    // Out-of-range channel requests saturate to the last channel.
    always_comb begin
        if (NCH == 1)
            req_ch = '0;
        else if (int'(s_cfg_ch_i) >= NCH)
            req_ch = CHW'(NCH - 1);
        else
            req_ch = s_cfg_ch_i;
    end

    assign quiet       = (act_cs == CS_OFF) && (pend_cs == CS_OFF);
    assign s_cfg_rdy_o = (state == S_IDLE);
    assign s_busy_o    = (state == S_WAIT);
    assign accept      = s_cfg_vld_i && s_cfg_rdy_o;
    assign same        = (s_cfg_sel_i == cur_sel) && (req_ch == cur_ch);

    always_comb begin
        state_d    = state;
        cur_sel_d  = cur_sel;
        cur_ch_d   = cur_ch;
        pend_sel_d = pend_sel;
        pend_ch_d  = pend_ch;
        cnt_d      = cnt;
`ifdef SPI_PIN_ARB_TIMEOUT_EN
        tmo_d      = tmo;
        err_d      = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                if (accept && !same) begin
                    pend_sel_d = s_cfg_sel_i;
                    pend_ch_d  = req_ch;
                    cnt_d      = '0;
                    state_d    = S_WAIT;
`ifdef SPI_PIN_ARB_TIMEOUT_EN
                    tmo_d      = '0;
`endif
                end
            end
            S_WAIT: begin
                if (!quiet) begin
                    cnt_d = '0;
                end else if (cnt == CNTW'(GUARD - 1)) begin
                    cur_sel_d = pend_sel;
                    cur_ch_d  = pend_ch;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
`ifdef SPI_PIN_ARB_TIMEOUT_EN
                // Applying on the last allowed cycle wins over the timeout.
                if (state_d == S_WAIT) begin
                    if (tmo == TW'(TMO - 1)) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        tmo_d = tmo + 1'b1;
                    end
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge s_clk_i or posedge s_rst_i) begin
        if (s_rst_i) begin
            state    <= S_IDLE;
            cur_sel  <= '0;
            cur_ch   <= '0;
            pend_sel <= '0;
            pend_ch  <= '0;
            cnt      <= '0;
            pin_q    <= PIN_RST;
        end else begin
            state    <= state_d;
            cur_sel  <= cur_sel_d;
            cur_ch   <= cur_ch_d;
            pend_sel <= pend_sel_d;
            pend_ch  <= pend_ch_d;
            cnt      <= cnt_d;
            pin_q    <= (cur_sel & spi_vec) | (~cur_sel & s_io_i);
        end
    end

`ifdef SPI_PIN_ARB_TIMEOUT_EN
    always_ff @(posedge s_clk_i or posedge s_rst_i) begin
        if (s_rst_i) begin
            tmo     <= '0;
            s_err_o <= 1'b0;
        end else begin
            tmo     <= tmo_d;
            s_err_o <= err_d;
        end
    end
`endif

    assign s_spi_clk_o = pin_q[0];
    assign s_spi_dat_o = pin_q[1];
    assign s_spi_cs_o  = pin_q[2 +: CS_W+1];
    assign s_spi_io_o  = pin_q[CS_W+3 +: IO_W+1];
    assign s_cur_sel_o = cur_sel;
    assign s_cur_ch_o  = cur_ch;

endmodule
